memref_mp_model: RTL and testbench
==================================

Name: memref_mp_model

Overview:
- Parametrised successor to the single-port memref_rd/memref_wr pair used in kernel testbenches.
- Provides one shared storage array with NUM_RD read ports and NUM_WR write ports.
- Read latency is configurable, and each read port has a valid output.
- Detects write conflicts and out-of-range accesses, and keeps access counters so HIR and HLS instances of a kernel can be compared on the same stimulus.
- Sits between a DUT's memory interface and the bench's clk_generator.

Parameters:
- WIDTH, 32, data width in bits.
- SIZE, 64, number of words; need not be a power of two.
- NUM_RD, 2, number of read ports (≥1).
- NUM_WR, 1, number of write ports (≥1).
- RD_LATENCY, 1, cycles from rd_en sample to rd_valid/rd_data (≥1).
- CNT_WIDTH, 32, width of the access counters.
- AW (derived, not overridable) = max(1, $clog2(SIZE)).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- rd_en  in  NUM_RD  per-port read request.
- rd_addr  in  NUM_RD*AW  port p address at bits [p*AW +: AW].
- rd_data  out  NUM_RD*WIDTH  port p data at bits [p*WIDTH +: WIDTH].
- rd_valid  out  NUM_RD  per-port data-valid strobe.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*AW  write addresses.
- wr_data  in  NUM_WR*WIDTH  write data.
- clr_stats  in  1  synchronous clear of counters and sticky flags.
- rd_count  out  CNT_WIDTH  accepted in-range reads, summed over all ports.
- wr_count  out  CNT_WIDTH  committed in-range writes, summed over all ports.
- err_oob  out  1  sticky: some access had addr ≥ SIZE.
- err_wr_conflict  out  1  sticky: two write ports hit the same address in the same cycle.

Behaviour:
- Reset (asynchronous assert, synchronous-style deassert):
  - rd_valid = 0, rd_data = 0, all read pipeline stages cleared.
  - rd_count = wr_count = 0, err_oob = err_wr_conflict = 0.
  - Storage array is NOT reset; the bench preloads it by hierarchical reference.
- Reset mid-operation: in-flight reads are discarded and no rd_valid is issued for them after rst deasserts.
- Read port p:
  - rd_en[p]=1 at edge N → rd_valid[p]=1 and rd_data valid at edge N+RD_LATENCY, for exactly one cycle per request.
  - Fully pipelined: one request per cycle per port, back-to-back accepted.
  - Data is sampled from the array at edge N (stage 1), then delayed RD_LATENCY-1 further register stages.
  - rd_data holds its last value while rd_valid=0.
- Read-during-write to the same address at the same edge returns the OLD contents (read-first).
- Writes commit at the edge where wr_en is sampled; visible to reads sampled at the next edge or later.
- Write conflict: two or more enabled write ports with the same in-range address at one edge:
  - The highest port index wins.
  - err_wr_conflict sets at that edge.
  - wr_count counts only the winning write.
- Out of range (addr ≥ SIZE):
  - Read: still returns rd_valid after latency, with rd_data = 0; not counted.
  - Write: ignored; not counted.
  - Either case sets err_oob.
- Counters:
  - Each edge, add popcount of in-range accepted reads / committed writes.
  - Saturate at 2^CNT_WIDTH-1; never wrap.
- clr_stats=1 at an edge: counters and sticky flags go to 0; events in that same cycle are not counted and do not set flags (clear wins).
- Data outputs carry no X after reset; reads of unwritten, un-preloaded words return whatever the array holds.

Test Plan:
- Preload mem[i]=i+1 (SIZE=64, RD_LATENCY=1); read port0 addr 5 at edge N → rd_valid[0]=1, rd_data[0]=6 at N+1; rd_count=1.
- RD_LATENCY=3; port0 reads addr 0,1,2 on consecutive edges, rst pulses for one cycle after the third request → no rd_valid ever issued; counters = 0 after reset.
- Same edge: write 0xDEAD to addr 32 on wr port0, read addr 32 on rd port1 (preload 33) → rd_data[1]=33; a read at the next edge returns 0xDEAD; wr_count=1.
- NUM_WR=2: port0 writes 0x11, port1 writes 0x22 to addr 7 at the same edge → mem[7]=0x22, err_wr_conflict=1, wr_count=1.
- SIZE=48: read addr 50 and write addr 63 → rd_valid=1 with rd_data=0, mem unchanged, err_oob=1, counts unchanged; then clr_stats → err_oob=0.
- CNT_WIDTH=4: 20 consecutive reads on both ports → rd_count holds at 15; clr_stats asserted in the same cycle as a read → rd_count=0 next cycle.

Source files
------------

// File: rtl/memref_mp_model.sv
// Multi-port behavioural memory for kernel benches: NUM_RD read / NUM_WR write ports, read-first,
// pipelined reads with valid strobes, sticky error flags and saturating access counters.
module memref_mp_model #(
  parameter int WIDTH      = 32,
  parameter int SIZE       = 64,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int RD_LATENCY = 1,
  parameter int CNT_WIDTH  = 32,
  localparam int AW        = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_RD-1:0]       rd_en,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_valid,
  input  logic [NUM_WR-1:0]       wr_en,
  input  logic [NUM_WR*AW-1:0]    wr_addr,
  input  logic [NUM_WR*WIDTH-1:0] wr_data,
  input  logic                    clr_stats,
  output logic [CNT_WIDTH-1:0]    rd_count,
  output logic [CNT_WIDTH-1:0]    wr_count,
  output logic                    err_oob,
  output logic                    err_wr_conflict
);

  logic [WIDTH-1:0] mem [SIZE];

  logic [NUM_RD-1:0]       vld_q [RD_LATENCY];
  logic [NUM_RD*WIDTH-1:0] dat_q [RD_LATENCY];

  logic [NUM_RD*WIDTH-1:0] rd_samp;
  int unsigned             rd_pop;
  logic                    rd_oob;
  logic [NUM_WR-1:0]       wr_ok;
  logic [NUM_WR-1:0]       wr_win;
  int unsigned             wr_pop;
  logic                    wr_oob;
  logic                    wr_conf;

  logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;
  logic [CNT_WIDTH-1:0] wr_count_q, wr_count_d;
  logic                 err_oob_q, err_oob_d;
  logic                 err_conf_q, err_conf_d;

  function automatic logic in_rng(input logic [AW-1:0] a);
    return ({{(32-AW){1'b0}}, a} < 32'(SIZE));
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                   input int unsigned n);
    logic [CNT_WIDTH+32:0] s;
    s = {33'd0, c} + {{(CNT_WIDTH+1){1'b0}}, n};
    if (s > {33'd0, {CNT_WIDTH{1'b1}}}) return '1;
    return s[CNT_WIDTH-1:0];
  endfunction

  always_comb begin
    rd_samp = '0;
    rd_pop  = 0;
    rd_oob  = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rd_en[p]) begin
        if (in_rng(rd_addr[p*AW +: AW])) begin
          rd_samp[p*WIDTH +: WIDTH] = mem[rd_addr[p*AW +: AW]];
          rd_pop = rd_pop + 1;
        end else begin
          rd_oob = 1'b1;
        end
      end
    end
  end

  // A write port loses only to a higher-indexed port hitting the same in-range word.
  always_comb begin
    wr_ok   = '0;
    wr_win  = '0;
    wr_pop  = 0;
    wr_oob  = 1'b0;
    wr_conf = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      wr_ok[i] = wr_en[i] && in_rng(wr_addr[i*AW +: AW]);
      if (wr_en[i] && !in_rng(wr_addr[i*AW +: AW])) wr_oob = 1'b1;
    end
    for (int i = 0; i < NUM_WR; i++) begin
      wr_win[i] = wr_ok[i];
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (wr_ok[i] && wr_ok[j] && (wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW])) begin
          wr_win[i] = 1'b0;
          wr_conf   = 1'b1;
        end
      end
      if (wr_win[i]) wr_pop = wr_pop + 1;
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_ok[p]) mem[wr_addr[p*AW +: AW]] <= wr_data[p*WIDTH +: WIDTH];
    end
  end

  // Data registers load only alongside a valid, so the output holds between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < RD_LATENCY; k++) begin
        vld_q[k] <= '0;
        dat_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= rd_en;
      for (int p = 0; p < NUM_RD; p++) begin
        if (rd_en[p]) dat_q[0][p*WIDTH +: WIDTH] <= rd_samp[p*WIDTH +: WIDTH];
      end
      for (int k = 1; k < RD_LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        for (int p = 0; p < NUM_RD; p++) begin
          if (vld_q[k-1][p]) dat_q[k][p*WIDTH +: WIDTH] <= dat_q[k-1][p*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    rd_count_d = '0;
    wr_count_d = '0;
    err_oob_d  = 1'b0;
    err_conf_d = 1'b0;
    if (!clr_stats) begin
      rd_count_d = sat_add(rd_count_q, rd_pop);
      wr_count_d = sat_add(wr_count_q, wr_pop);
      err_oob_d  = err_oob_q | rd_oob | wr_oob;
      err_conf_d = err_conf_q | wr_conf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
      err_oob_q  <= 1'b0;
      err_conf_q <= 1'b0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      err_oob_q  <= err_oob_d;
      err_conf_q <= err_conf_d;
    end
  end

  assign rd_valid        = vld_q[RD_LATENCY-1];
  assign rd_data         = dat_q[RD_LATENCY-1];
  assign rd_count        = rd_count_q;
  assign wr_count        = wr_count_q;
  assign err_oob         = err_oob_q;
  assign err_wr_conflict = err_conf_q;

endmodule

// File: tb/tb_memref_mp_model.sv
// Directed bench: u0 = 64 words, 2 rd / 2 wr, latency 1; u1 = 48 words, latency 3, 4-bit counters.
module tb_memref_mp_model;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, clr0, oob0, conf0;
  logic [1:0]  rd_en0, rd_valid0, wr_en0;
  logic [11:0] rd_addr0, wr_addr0;
  logic [63:0] rd_data0, wr_data0;
  logic [31:0] rd_cnt0, wr_cnt0;

  logic        rst1, clr1, oob1, conf1;
  logic [1:0]  rd_en1, rd_valid1;
  logic [0:0]  wr_en1;
  logic [11:0] rd_addr1;
  logic [5:0]  wr_addr1;
  logic [63:0] rd_data1;
  logic [31:0] wr_data1;
  logic [3:0]  rd_cnt1, wr_cnt1;

  int total = 0;
  int bad   = 0;
  logic seen;

  memref_mp_model #(.WIDTH(32), .SIZE(64), .NUM_RD(2), .NUM_WR(2), .RD_LATENCY(1), .CNT_WIDTH(32)) u0 (
    .clk(clk), .rst(rst0), .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .clr_stats(clr0), .rd_count(rd_cnt0), .wr_count(wr_cnt0), .err_oob(oob0),
    .err_wr_conflict(conf0));

  memref_mp_model #(.WIDTH(32), .SIZE(48), .NUM_RD(2), .NUM_WR(1), .RD_LATENCY(3), .CNT_WIDTH(4)) u1 (
    .clk(clk), .rst(rst1), .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .clr_stats(clr1), .rd_count(rd_cnt1), .wr_count(wr_cnt1), .err_oob(oob1),
    .err_wr_conflict(conf1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; clr0 = 1'b0; clr1 = 1'b0;
    rd_en0 = '0; rd_addr0 = '0; wr_en0 = '0; wr_addr0 = '0; wr_data0 = '0;
    rd_en1 = '0; rd_addr1 = '0; wr_en1 = '0; wr_addr1 = '0; wr_data1 = '0;
    #1;
    for (int i = 0; i < 64; i++) u0.mem[i] = 32'(i + 1);
    for (int i = 0; i < 48; i++) u1.mem[i] = 32'(i + 1);
    repeat (2) @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("rst_vld0", 64'(rd_valid0), 64'd0);
    chk("rst_dat0", rd_data0, 64'd0);
    chk("rst_cnt0", {rd_cnt0, wr_cnt0}, 64'd0);
    chk("rst_flags0", {62'd0, oob0, conf0}, 64'd0);
    chk("rst_vld1", 64'(rd_valid1), 64'd0);
    chk("rst_cnt1", {56'd0, rd_cnt1, wr_cnt1}, 64'd0);

    // basic latency-1 read of preloaded word
    rd_en0 = 2'b01; rd_addr0 = 12'd5;
    @(negedge clk);
    rd_en0 = 2'b00;
    chk("t1_vld", 64'(rd_valid0), 64'd1);
    chk("t1_dat", 64'(rd_data0[31:0]), 64'd6);
    chk("t1_cnt", 64'(rd_cnt0), 64'd1);
    @(negedge clk);
    chk("t1_vld_drop", 64'(rd_valid0), 64'd0);
    chk("t1_dat_hold", 64'(rd_data0[31:0]), 64'd6);

    // read-during-write returns old data
    wr_en0 = 2'b01; wr_addr0 = 12'd32; wr_data0 = 64'h0000_DEAD;
    rd_en0 = 2'b10; rd_addr0 = {6'd32, 6'd0};
    @(negedge clk);
    wr_en0 = 2'b00;
    chk("rdw_vld", 64'(rd_valid0), 64'd2);
    chk("rdw_old", 64'(rd_data0[63:32]), 64'd33);
    @(negedge clk);
    rd_en0 = 2'b00;
    chk("rdw_new", 64'(rd_data0[63:32]), 64'hDEAD);
    chk("rdw_wcnt", 64'(wr_cnt0), 64'd1);
    chk("rdw_rcnt", 64'(rd_cnt0), 64'd3);

    // write conflict: highest port wins, counted once
    wr_en0 = 2'b11; wr_addr0 = {6'd7, 6'd7}; wr_data0 = {32'h22, 32'h11};
    @(negedge clk);
    wr_en0 = 2'b00;
    chk("conf_flag", 64'(conf0), 64'd1);
    chk("conf_wcnt", 64'(wr_cnt0), 64'd2);
    rd_en0 = 2'b01; rd_addr0 = 12'd7;
    @(negedge clk);
    rd_en0 = 2'b00;
    chk("conf_win", 64'(rd_data0[31:0]), 64'h22);

    // clear wins over a same-cycle read
    clr0 = 1'b1; rd_en0 = 2'b01; rd_addr0 = 12'd3;
    @(negedge clk);
    clr0 = 1'b0; rd_en0 = 2'b00;
    chk("clr0_cnt", {rd_cnt0, wr_cnt0}, 64'd0);
    chk("clr0_conf", 64'(conf0), 64'd0);
    wr_en0 = 2'b11; wr_addr0 = {6'd9, 6'd8}; wr_data0 = {32'h99, 32'h88};
    @(negedge clk);
    wr_en0 = 2'b00;
    chk("nocf_wcnt", 64'(wr_cnt0), 64'd2);
    chk("nocf_flag", 64'(conf0), 64'd0);

    // reset with reads in flight (latency 3)
    rd_en1 = 2'b01; rd_addr1 = 12'd0;
    @(negedge clk);
    rd_addr1 = 12'd1;
    @(negedge clk);
    chk("mid_cnt_pre", 64'(rd_cnt1), 64'd2);
    rd_addr1 = 12'd2;
    @(posedge clk);
    #1 rst1 = 1'b1; rd_en1 = 2'b00;
    @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rd_valid1 != 2'b00) seen = 1'b1;
    end
    chk("mid_no_vld", 64'(seen), 64'd0);
    chk("mid_cnt", {56'd0, rd_cnt1, wr_cnt1}, 64'd0);

    // latency-3 timing
    rd_en1 = 2'b01; rd_addr1 = 12'd4;
    @(negedge clk);
    rd_en1 = 2'b00;
    chk("lat3_e0", 64'(rd_valid1), 64'd0);
    @(negedge clk);
    chk("lat3_e1", 64'(rd_valid1), 64'd0);
    @(negedge clk);
    chk("lat3_vld", 64'(rd_valid1), 64'd1);
    chk("lat3_dat", 64'(rd_data1[31:0]), 64'd5);
    @(negedge clk);
    chk("lat3_once", 64'(rd_valid1), 64'd0);

    // out of range read and write on 48-word array
    rd_en1 = 2'b01; rd_addr1 = 12'd50; wr_en1 = 1'b1; wr_addr1 = 6'd63; wr_data1 = 32'hFF;
    @(negedge clk);
    rd_en1 = 2'b00; wr_en1 = 1'b0;
    chk("oob_flag", 64'(oob1), 64'd1);
    chk("oob_rcnt", 64'(rd_cnt1), 64'd1);
    chk("oob_wcnt", 64'(wr_cnt1), 64'd0);
    repeat (2) @(negedge clk);
    chk("oob_vld", 64'(rd_valid1), 64'd1);
    chk("oob_dat", 64'(rd_data1[31:0]), 64'd0);
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    chk("oob_clr", 64'(oob1), 64'd0);

    // counter saturation on 4-bit counters
    rd_en1 = 2'b11; rd_addr1 = {6'd1, 6'd1};
    repeat (7) @(negedge clk);
    chk("sat_14", 64'(rd_cnt1), 64'd14);
    repeat (13) @(negedge clk);
    chk("sat_hold", 64'(rd_cnt1), 64'd15);
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0; rd_en1 = 2'b00;
    chk("sat_clr", 64'(rd_cnt1), 64'd0);
    @(negedge clk);
    chk("sat_clr_stay", 64'(rd_cnt1), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
